// File: rtl/leaf_request_merger_pkg.sv
// Shared widths and the request layout for the two-port leaf request merger.
package leaf_request_merger_pkg;

   localparam int unsigned DSIZE             = 11;
   localparam int unsigned DEF_ADDRESS_WIDTH = 8;
   localparam int unsigned DEF_PATCH_WIDTH   = 5 * DSIZE;

   typedef struct packed {
      logic                         port;
      logic [DEF_ADDRESS_WIDTH-1:0] index;
      logic [DEF_PATCH_WIDTH-1:0]   patch;
   } leaf_req_t;

endpackage

// File: rtl/dual_push_fifo.sv
// In-order FIFO with two write ports (a lands ahead of b) and one read port.
module dual_push_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push_a,
   input  logic [WIDTH-1:0]           data_a,
   input  logic                       push_b,
   input  logic [WIDTH-1:0]           data_b,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_b_ptr;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_b_ptr = push_a ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; writes during clear are harmless since pointers restart.
   always_ff @(posedge clk) begin
      if (push_a) mem[wr_ptr_q] <= data_a;
      if (push_b) mem[wr_b_ptr] <= data_b;
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/leaf_request_merger.sv
// Merges the two tree result ports into one ordered request stream, dropping on overflow.
module leaf_request_merger
   import leaf_request_merger_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int unsigned PATCH_WIDTH   = DEF_PATCH_WIDTH,
   parameter int unsigned DEPTH         = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      leaf_en,
   input  logic [ADDRESS_WIDTH-1:0]  leaf_index,
   input  logic [PATCH_WIDTH-1:0]    patch_in,
   input  logic                      leaf_two_en,
   input  logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
   input  logic [PATCH_WIDTH-1:0]    patch_in_two,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ADDRESS_WIDTH-1:0]  out_index,
   output logic [PATCH_WIDTH-1:0]    out_patch,
   output logic                      out_port,
   output logic [$clog2(DEPTH):0]    occupancy,
   output logic                      overflow
);

   localparam int unsigned OCC_W   = $clog2(DEPTH) + 1;
   localparam int unsigned ENTRY_W = 1 + ADDRESS_WIDTH + PATCH_WIDTH;

   logic [ENTRY_W-1:0] entry0, entry1, head;
   logic [OCC_W-1:0]   count;
   logic [OCC_W:0]     free;
   logic               pop, accept0, accept1, drop;
   logic               overflow_q, overflow_d;

   assign entry0 = {1'b0, leaf_index, patch_in};
   assign entry1 = {1'b1, leaf_index_two, patch_in_two};

   // A same-cycle pop frees its slot before pushes are counted against space.
   always_comb begin
      pop     = out_valid & out_ready;
      free    = (OCC_W+1)'(DEPTH) - {1'b0, count} + (OCC_W+1)'(pop);
      accept0 = leaf_en & (free != '0);
      accept1 = leaf_two_en & (accept0 ? (free > (OCC_W+1)'(1)) : (free != '0));
      drop    = (leaf_en & ~accept0) | (leaf_two_en & ~accept1);
      overflow_d = overflow_q | drop;
      if (flush) overflow_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;
   end

   dual_push_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (flush),
      .push_a (accept0),
      .data_a (entry0),
      .push_b (accept1),
      .data_b (entry1),
      .pop    (pop),
      .head   (head),
      .count  (count)
   );

   // Head fields are forced to zero when empty so reset and idle never expose stale RAM.
   always_comb begin
      out_valid = (count != '0);
      out_port  = out_valid & head[ENTRY_W-1];
      out_index = out_valid ? head[PATCH_WIDTH +: ADDRESS_WIDTH] : '0;
      out_patch = out_valid ? head[PATCH_WIDTH-1:0] : '0;
   end

   assign occupancy = count;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_leaf_request_merger.sv
// Bench for leaf_request_merger: directed scenarios plus a random run against a queue model.
module tb_leaf_request_merger;
   import leaf_request_merger_pkg::*;

   localparam int AW = 8;
   localparam int PW = 55;
   localparam int DEPTH = 8;
   localparam int OW = 4;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          leaf_en = 1'b0, leaf_two_en = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [AW-1:0] leaf_index = '0, leaf_index_two = '0;
   logic [PW-1:0] patch_in = '0, patch_in_two = '0;
   logic          out_valid, out_port, overflow;
   logic [AW-1:0] out_index;
   logic [PW-1:0] out_patch;
   logic [OW-1:0] occupancy;

   int nvec = 0;
   int nbad = 0;
   leaf_req_t model_q[$];
   bit model_ovf = 1'b0;
   int model_drops = 0;

   always #5 clk = ~clk;

   leaf_request_merger #(.ADDRESS_WIDTH(AW), .PATCH_WIDTH(PW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .leaf_en(leaf_en), .leaf_index(leaf_index), .patch_in(patch_in),
      .leaf_two_en(leaf_two_en), .leaf_index_two(leaf_index_two), .patch_in_two(patch_in_two),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_patch(out_patch), .out_port(out_port),
      .occupancy(occupancy), .overflow(overflow)
   );

   function automatic logic [PW-1:0] rand_patch();
      return PW'({$urandom(), $urandom()});
   endfunction

   // Reference: pop first, then port 0 and port 1 each take a slot if one is left.
   task automatic model_update();
      int free;
      leaf_req_t e;
      if (!rst_n || flush) begin
         model_q.delete();
         model_ovf = 1'b0;
         return;
      end
      free = DEPTH - model_q.size();
      if (out_ready && model_q.size() != 0) begin
         void'(model_q.pop_front());
         free++;
      end
      if (leaf_en) begin
         if (free > 0) begin
            e.port = 1'b0; e.index = leaf_index; e.patch = patch_in;
            model_q.push_back(e); free--;
         end else begin
            model_ovf = 1'b1; model_drops++;
         end
      end
      if (leaf_two_en) begin
         if (free > 0) begin
            e.port = 1'b1; e.index = leaf_index_two; e.patch = patch_in_two;
            model_q.push_back(e); free--;
         end else begin
            model_ovf = 1'b1; model_drops++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      nvec++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      nvec++; if (occupancy !== '0) begin nbad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
      nvec++; if (overflow !== 1'b0) begin nbad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
      nvec++; if (out_port !== 1'b0) begin nbad++; $display("FAIL reset_port got=%b exp=0", out_port); end
      nvec++; if (out_index !== '0) begin nbad++; $display("FAIL reset_index got=%0d exp=0", out_index); end
      nvec++; if (out_patch !== '0) begin nbad++; $display("FAIL reset_patch got=%h exp=0", out_patch); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [PW-1:0] p0, p1;
      p0 = rand_patch(); p1 = rand_patch();
      out_ready = 1'b1;
      leaf_en = 1'b1; leaf_index = 8'd59; patch_in = p0;
      #1;
      nvec++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL single_nobypass got=%b exp=0", out_valid); end
      tick();
      leaf_en = 1'b0; leaf_two_en = 1'b1; leaf_index_two = 8'd60; patch_in_two = p1;
      nvec++; if (out_valid !== 1'b1) begin nbad++; $display("FAIL single_valid0 got=%b exp=1", out_valid); end
      nvec++; if (out_port !== 1'b0) begin nbad++; $display("FAIL single_port0 got=%b exp=0", out_port); end
      nvec++; if (out_index !== 8'd59) begin nbad++; $display("FAIL single_index0 got=%0d exp=59", out_index); end
      nvec++; if (out_patch !== p0) begin nbad++; $display("FAIL single_patch0 got=%h exp=%h", out_patch, p0); end
      tick();
      leaf_two_en = 1'b0;
      nvec++; if (out_port !== 1'b1) begin nbad++; $display("FAIL single_port1 got=%b exp=1", out_port); end
      nvec++; if (out_index !== 8'd60) begin nbad++; $display("FAIL single_index1 got=%0d exp=60", out_index); end
      nvec++; if (out_patch !== p1) begin nbad++; $display("FAIL single_patch1 got=%h exp=%h", out_patch, p1); end
      tick();
      nvec++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b0;
      leaf_en = 1'b1; leaf_index = 8'd22; patch_in = rand_patch();
      leaf_two_en = 1'b1; leaf_index_two = 8'd5; patch_in_two = rand_patch();
      tick();
      leaf_en = 1'b0; leaf_two_en = 1'b0;
      nvec++; if (occupancy !== 4'd2) begin nbad++; $display("FAIL simul_occ got=%0d exp=2", occupancy); end
      nvec++; if ({out_port, out_index} !== {1'b0, 8'd22}) begin nbad++; $display("FAIL simul_head0 got=%b/%0d exp=0/22", out_port, out_index); end
      tick();
      nvec++; if (out_index !== 8'd22) begin nbad++; $display("FAIL simul_hold got=%0d exp=22", out_index); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      nvec++; if ({out_port, out_index} !== {1'b1, 8'd5}) begin nbad++; $display("FAIL simul_head1 got=%b/%0d exp=1/5", out_port, out_index); end
      nvec++; if (occupancy !== 4'd1) begin nbad++; $display("FAIL simul_occ1 got=%0d exp=1", occupancy); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_pop_push_full();
      for (int i = 0; i < 8; i++) begin
         leaf_en = 1'b1; leaf_index = AW'(100 + i); patch_in = rand_patch();
         tick();
      end
      nvec++; if (occupancy !== 4'd8) begin nbad++; $display("FAIL full_occ got=%0d exp=8", occupancy); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         leaf_index = AW'(77 + i);
         tick();
         nvec++; if (occupancy !== 4'd8) begin nbad++; $display("FAIL poppush_occ got=%0d exp=8", occupancy); end
         nvec++; if (overflow !== 1'b0) begin nbad++; $display("FAIL poppush_ovf got=%b exp=0", overflow); end
      end
      leaf_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         automatic int exp_idx = (i < 5) ? 103 + i : 77 + i - 5;
         nvec++; if (out_index !== AW'(exp_idx)) begin nbad++; $display("FAIL wrap_order%0d got=%0d exp=%0d", i, out_index, exp_idx); end
         tick();
      end
      out_ready = 1'b0;
      nvec++; if (occupancy !== 4'd0) begin nbad++; $display("FAIL wrap_empty got=%0d exp=0", occupancy); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 7; i++) begin
         leaf_en = 1'b1; leaf_index = AW'(i); patch_in = rand_patch();
         tick();
      end
      leaf_index = 8'd24; leaf_two_en = 1'b1; leaf_index_two = 8'd30;
      tick();
      leaf_two_en = 1'b0;
      nvec++; if (occupancy !== 4'd8) begin nbad++; $display("FAIL ovf_occ got=%0d exp=8", occupancy); end
      nvec++; if (overflow !== 1'b1) begin nbad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      leaf_index = 8'd99;
      tick();
      leaf_en = 1'b0;
      nvec++; if (occupancy !== 4'd8) begin nbad++; $display("FAIL ovf_full got=%0d exp=8", occupancy); end
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      out_ready = 1'b0;
      nvec++; if (out_index !== 8'd24) begin nbad++; $display("FAIL ovf_last got=%0d exp=24", out_index); end
      nvec++; if (overflow !== 1'b1) begin nbad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      nvec++; if ({occupancy, overflow} !== 5'd0) begin nbad++; $display("FAIL flush1 got=%0d/%b exp=0/0", occupancy, overflow); end
      leaf_en = 1'b1;
      repeat (3) tick();
      nvec++; if (occupancy !== 4'd3) begin nbad++; $display("FAIL flush_fill got=%0d exp=3", occupancy); end
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; leaf_en = 1'b0; out_ready = 1'b0;
      nvec++; if (occupancy !== 4'd0) begin nbad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
      nvec++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      leaf_en = 1'b1; leaf_two_en = 1'b1; leaf_index = 8'd9;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      model_q.delete(); model_ovf = 1'b0;
      nvec++; if ({out_valid, out_port, occupancy, overflow} !== '0) begin nbad++; $display("FAIL rstmid_ctl got=%b%b/%0d/%b exp=0", out_valid, out_port, occupancy, overflow); end
      nvec++; if ({out_index, out_patch} !== '0) begin nbad++; $display("FAIL rstmid_data got=%0d/%h exp=0", out_index, out_patch); end
      leaf_two_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      leaf_en = 1'b0;
      nvec++; if ({occupancy, out_index} !== {4'd1, 8'd9}) begin nbad++; $display("FAIL rstmid_first got=%0d/%0d exp=1/9", occupancy, out_index); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 2000; c++) begin
         leaf_en = ($urandom_range(0, 99) < 45);
         leaf_two_en = ($urandom_range(0, 99) < 45);
         leaf_index = AW'($urandom_range(0, 255)); patch_in = rand_patch();
         leaf_index_two = AW'($urandom_range(0, 255)); patch_in_two = rand_patch();
         out_ready = ($urandom_range(0, 99) < 55);
         flush = ($urandom_range(0, 199) == 0);
         tick();
         nvec++; if (out_valid !== (model_q.size() != 0)) begin nbad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, model_q.size() != 0); end
         nvec++; if (occupancy !== OW'(model_q.size())) begin nbad++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occupancy, model_q.size()); end
         nvec++; if (overflow !== model_ovf) begin nbad++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, overflow, model_ovf); end
         if (model_q.size() != 0) begin
            nvec++;
            if ({out_port, out_index, out_patch} !== {model_q[0].port, model_q[0].index, model_q[0].patch}) begin
               nbad++;
               $display("FAIL rnd_head c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, out_port, out_index,
                        out_patch, model_q[0].port, model_q[0].index, model_q[0].patch);
            end
         end
      end
      leaf_en = 1'b0; leaf_two_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_pop_push_full();
      test_overflow();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
